// File: rtl/clk_mux_pkg.sv
// Shared types and default sizing for the glitchless clock-select controller.
package clk_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam int DEF_NUM_CLOCKS  = 4;
  localparam int DEF_HOLD_CYCLES = 16;

endpackage

// File: rtl/clk_sel_hold_timer.sv
// Down-counter used to time the drain and settle phases of a clock switch.
module clk_sel_hold_timer
  import clk_mux_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  localparam int CW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: load wins over decrement; saturate at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != {CW{1'b0}})) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == {CW{1'b0}});

endmodule

// File: rtl/clk_select_ctrl.sv
// Sequences a break-before-make switch of a one-hot clock-mux select:
// all selects low for a drain period, new select high, then a settle period.
module clk_select_ctrl
  import clk_mux_pkg::*;
#(
  parameter int NUM_CLOCKS  = DEF_NUM_CLOCKS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int RESET_SEL   = 0,
  localparam int SELW = ($clog2(NUM_CLOCKS) > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [SELW-1:0]       req_sel,
  output logic                  req_ready,
  output logic [NUM_CLOCKS-1:0] clk_select,
  output logic [SELW-1:0]       cur_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [NUM_CLOCKS-1:0] RESET_ONEHOT =
    {{(NUM_CLOCKS-1){1'b0}}, 1'b1} << RESET_SEL;

  if (NUM_CLOCKS < 2) begin : g_bad_num_clocks
    $error("clk_select_ctrl: NUM_CLOCKS must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("clk_select_ctrl: HOLD_CYCLES must be at least 1");
  end
  if ((RESET_SEL < 0) || (RESET_SEL >= NUM_CLOCKS)) begin : g_bad_reset_sel
    $error("clk_select_ctrl: RESET_SEL must be below NUM_CLOCKS");
  end

  state_e                  state_q, state_d;
  logic [NUM_CLOCKS-1:0]   clk_select_q, clk_select_d;
  logic [SELW-1:0]         cur_sel_q, cur_sel_d;
  logic [SELW-1:0]         target_q, target_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [NUM_CLOCKS-1:0]   target_onehot_s;
  logic                    tmr_load_s;
  logic                    tmr_dec_s;
  logic                    tmr_expired_s;
  logic                    out_of_range_s;

  clk_sel_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .dec      (tmr_dec_s),
    .load_val (HOLD_LOAD),
    .expired  (tmr_expired_s)
  );

  assign out_of_range_s = ({1'b0, req_sel} >= (SELW+1)'(NUM_CLOCKS));

  // One-hot decode of the latched target index.
  always_comb begin
    target_onehot_s = {NUM_CLOCKS{1'b0}};
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      target_onehot_s[i] = (target_q == SELW'(i));
    end
  end

  // Next-state and output decode; requests are only looked at in IDLE.
  always_comb begin
    state_d      = state_q;
    clk_select_d = clk_select_q;
    cur_sel_d    = cur_sel_q;
    target_d     = target_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    tmr_load_s   = 1'b0;
    tmr_dec_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (out_of_range_s) begin
            err_d = 1'b1;
          end else if (req_sel == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            target_d     = req_sel;
            clk_select_d = {NUM_CLOCKS{1'b0}};
            tmr_load_s   = 1'b1;
            state_d      = ST_DRAIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (tmr_expired_s) begin
          clk_select_d = target_onehot_s;
          cur_sel_d    = target_q;
          tmr_load_s   = 1'b1;
          state_d      = ST_SETTLE;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_expired_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers; reset drops any switch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clk_select_q <= RESET_ONEHOT;
      cur_sel_q    <= SELW'(RESET_SEL);
      target_q     <= SELW'(RESET_SEL);
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_select_q <= clk_select_d;
      cur_sel_q    <= cur_sel_d;
      target_q     <= target_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign clk_select = clk_select_q;
  assign cur_sel    = cur_sel_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_IDLE);
  assign req_ready  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_clk_select_ctrl.sv
// Bench for clk_select_ctrl: directed switches plus a random request phase,
// with done/err events checked against a queue of expected events.
module tb_clk_select_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready, busy, done, err;
  logic [3:0] clk_select;
  logic [1:0] cur_sel;

  logic       r3_valid;
  logic [1:0] r3_sel;
  logic       r3_ready, r3_busy, r3_done, r3_err;
  logic [2:0] r3_clk_select;
  logic [1:0] r3_cur_sel;

  clk_select_ctrl #(.NUM_CLOCKS(4), .HOLD_CYCLES(4), .RESET_SEL(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .clk_select(clk_select), .cur_sel(cur_sel),
    .busy(busy), .done(done), .err(err)
  );

  clk_select_ctrl #(.NUM_CLOCKS(3), .HOLD_CYCLES(4), .RESET_SEL(0)) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_sel(r3_sel),
    .req_ready(r3_ready), .clk_select(r3_clk_select), .cur_sel(r3_cur_sel),
    .busy(r3_busy), .done(r3_done), .err(r3_err)
  );

  typedef struct {
    logic        is_err;
    logic [3:0]  csel;
    logic [1:0]  cur;
    int unsigned cyc;
  } exp_t;

  exp_t        q4[$];
  exp_t        q3[$];
  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 4-clock instance: invariants every cycle, events vs queue.
  always @(negedge clk) begin
    exp_t e;
    chk("onehot0_4", 32'($onehot0(clk_select)), 32'd1);
    chk("done_err_excl_4", {31'd0, done & err}, 32'd0);
    if (done || err) begin
      if (q4.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_event_4: done=%0b err=%0b at cycle %0d, expected none", done, err, cyc);
      end else begin
        e = q4.pop_front();
        chk("evt4_err", {31'd0, err}, {31'd0, e.is_err});
        chk("evt4_done", {31'd0, done}, {31'd0, ~e.is_err});
        chk("evt4_clk_select", {28'd0, clk_select}, {28'd0, e.csel});
        chk("evt4_cur_sel", {30'd0, cur_sel}, {30'd0, e.cur});
        chk("evt4_cycle", cyc, e.cyc);
      end
    end
    if ((q4.size() != 0) && (q4[0].cyc < cyc)) begin
      e = q4.pop_front();
      compared++; mismatched++;
      $display("FAIL missed_event_4: event expected at cycle %0d did not occur", e.cyc);
    end
  end

  // Monitor for the 3-clock instance.
  always @(negedge clk) begin
    exp_t e;
    chk("onehot0_3", 32'($onehot0(r3_clk_select)), 32'd1);
    chk("done_err_excl_3", {31'd0, r3_done & r3_err}, 32'd0);
    if (r3_done || r3_err) begin
      if (q3.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_event_3: done=%0b err=%0b at cycle %0d, expected none", r3_done, r3_err, cyc);
      end else begin
        e = q3.pop_front();
        chk("evt3_err", {31'd0, r3_err}, {31'd0, e.is_err});
        chk("evt3_done", {31'd0, r3_done}, {31'd0, ~e.is_err});
        chk("evt3_clk_select", {28'd0, 1'b0, r3_clk_select}, {28'd0, e.csel});
        chk("evt3_cur_sel", {30'd0, r3_cur_sel}, {30'd0, e.cur});
        chk("evt3_cycle", cyc, e.cyc);
      end
    end
    if ((q3.size() != 0) && (q3[0].cyc < cyc)) begin
      e = q3.pop_front();
      compared++; mismatched++;
      $display("FAIL missed_event_3: event expected at cycle %0d did not occur", e.cyc);
    end
  end

  // Full switch on the 4-clock instance, timeline checked cycle by cycle.
  // With hold_req, a request for index 1 is held during cycles 2..6.
  task automatic do_switch(input logic [1:0] tgt, input bit hold_req);
    logic [3:0] oh;
    int unsigned c;
    oh = 4'b0001 << tgt;
    c = cyc;
    req_valid = 1'b1;
    req_sel = tgt;
    q4.push_back('{1'b0, oh, tgt, c + 32'd9});
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("sw_clk_select", {28'd0, clk_select}, (k <= 4) ? 32'd0 : {28'd0, oh});
      chk("sw_busy", {31'd0, busy}, (k <= 8) ? 32'd1 : 32'd0);
      chk("sw_req_ready", {31'd0, req_ready}, (k == 9) ? 32'd1 : 32'd0);
      if (k >= 5) chk("sw_cur_sel", {30'd0, cur_sel}, {30'd0, tgt});
      req_valid = hold_req && (k >= 2) && (k <= 6);
      req_sel = 2'd1;
    end
    repeat (3) begin
      @(negedge clk);
      chk("sw_final_clk_select", {28'd0, clk_select}, {28'd0, oh});
    end
  endtask

  initial begin
    int unsigned c;
    int unsigned free_at;
    logic [1:0]  model_cur;
    logic        v;
    logic [1:0]  s;

    rst = 1'b1; req_valid = 1'b0; req_sel = 2'd0; r3_valid = 1'b0; r3_sel = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_clk_select", {28'd0, clk_select}, 32'h1);
    chk("rst_cur_sel", {30'd0, cur_sel}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_clk_select_3", {29'd0, r3_clk_select}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // 0 -> 2 with a request held while busy, then same-index, then 2 -> 0.
    do_switch(2'd2, 1'b1);
    c = cyc;
    req_valid = 1'b1; req_sel = 2'd2;
    q4.push_back('{1'b0, 4'b0100, 2'd2, c + 32'd1});
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("same_busy", {31'd0, busy}, 32'd0);
      chk("same_clk_select", {28'd0, clk_select}, 32'h4);
    end
    do_switch(2'd0, 1'b0);

    // Reset in cycle 2 of a 0 -> 3 switch.
    req_valid = 1'b1; req_sel = 2'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_drain_clk_select", {28'd0, clk_select}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_clk_select", {28'd0, clk_select}, 32'h1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_cur_sel", {30'd0, cur_sel}, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_final_clk_select", {28'd0, clk_select}, 32'h1);

    // 3-clock instance: out-of-range request, then a real switch to 2.
    c = cyc;
    r3_valid = 1'b1; r3_sel = 2'd3;
    q3.push_back('{1'b1, 4'b0001, 2'd0, c + 32'd1});
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      r3_valid = 1'b0;
      chk("oor_clk_select_3", {29'd0, r3_clk_select}, 32'h1);
      chk("oor_busy_3", {31'd0, r3_busy}, 32'd0);
      chk("oor_cur_sel_3", {30'd0, r3_cur_sel}, 32'd0);
    end
    c = cyc;
    r3_valid = 1'b1; r3_sel = 2'd2;
    q3.push_back('{1'b0, 4'b0100, 2'd2, c + 32'd9});
    @(posedge clk);
    @(negedge clk);
    r3_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("sw_clk_select_3", {29'd0, r3_clk_select}, 32'h4);

    // Random requests on the 4-clock instance; events predicted by a timing model.
    model_cur = 2'd0;
    free_at = cyc;
    for (int i = 0; i < 10000; i++) begin
      c = cyc;
      v = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      req_valid = v;
      req_sel = s;
      if (v && (c >= free_at)) begin
        if (s == model_cur) begin
          q4.push_back('{1'b0, 4'b0001 << s, s, c + 32'd1});
          free_at = c + 32'd1;
        end else begin
          q4.push_back('{1'b0, 4'b0001 << s, s, c + 32'd9});
          free_at = c + 32'd9;
          model_cur = s;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("final_queue_4_empty", q4.size(), 32'd0);
    chk("final_queue_3_empty", q3.size(), 32'd0);
    chk("final_cur_sel", {30'd0, cur_sel}, {30'd0, model_cur});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clk_select_ctrl.md
CLK_SELECT_CTRL -- requirements
Module: clk_select_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CLOCKS, default 4, giving the number of selectable clocks (minimum 2).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16, giving the cycles held in each of the drain and settle phases (minimum 1; elaboration error otherwise).
REQ-003 The block SHALL have parameter RESET_SEL, default 0, giving the clock index selected out of reset (must be < NUM_CLOCKS).
REQ-004 The block SHALL define SELW = max(1, clog2(NUM_CLOCKS)).
REQ-005 The block SHALL have port clk, input, 1 bit: the single always-running control clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port req_valid, input, 1 bit: a switch request is present.
REQ-008 The block SHALL have port req_sel, input, SELW bits: the requested clock index.
REQ-009 The block SHALL have port req_ready, output, 1 bit: a request is accepted this cycle.
REQ-010 The block SHALL have port clk_select, output, NUM_CLOCKS bits: registered one-hot/all-zero select driving the glitchless clock mux.
REQ-011 The block SHALL have port cur_sel, output, SELW bits: index of the currently selected clock.
REQ-012 The block SHALL have port busy, output, 1 bit: a switch is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on switch completion.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse on an out-of-range request.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, DRAIN and SETTLE; busy SHALL equal (state != IDLE), and req_ready SHALL equal (state == IDLE).
REQ-016 A request SHALL be accepted on the clk edge where req_valid and req_ready are both 1.
REQ-017 An accepted request with req_sel >= NUM_CLOCKS SHALL pulse err for the next cycle and leave state, clk_select and cur_sel unchanged.
REQ-018 An accepted request with req_sel == cur_sel SHALL pulse done for the next cycle, stay in IDLE, and leave clk_select unchanged (no zero gap).
REQ-019 Any other accepted request SHALL latch the target, drive clk_select all-zero from the next cycle, load the hold counter with HOLD_CYCLES-1, and enter DRAIN.
REQ-020 In DRAIN the hold counter SHALL decrement each cycle; when it reaches 0, the block SHALL set clk_select to one-hot(target) and cur_sel to target on the next edge, reload the counter, and enter SETTLE.
REQ-021 In SETTLE the counter SHALL decrement each cycle; when it reaches 0, the block SHALL enter IDLE on the next edge with done high for that one cycle.
REQ-022 Timing, for acceptance at edge T0: clk_select = 0 for cycles 1..H; one-hot(target) from cycle H+1; done and req_ready high in cycle 2H+1.
REQ-023 req_valid while busy SHALL be ignored, with no queueing and no effect on the switch in progress.
REQ-024 clk_select SHALL be a flop output with at most one bit set in every cycle.
REQ-025 done and err SHALL never be high in the same cycle.

Reset
REQ-026 While rst is high at a clk edge, the block SHALL enter IDLE and set clk_select = one-hot(RESET_SEL), cur_sel = RESET_SEL, counter = 0, done = 0 and err = 0.
REQ-027 Reset asserted mid-DRAIN or mid-SETTLE SHALL abort the switch immediately and produce no done pulse.

Structure
REQ-028 Package clk_mux_pkg SHALL hold the FSM state enum typedef and the default NUM_CLOCKS/HOLD_CYCLES constants.
REQ-029 The hold counter SHALL be a sub-module clk_sel_hold_timer (load value, decrement, expired flag), width clog2(HOLD_CYCLES+1).

Verification (NUM_CLOCKS=4, HOLD_CYCLES=4 unless stated)
REQ-030 Reset: rst high for 2 cycles -> clk_select=4'b0001, cur_sel=0, req_ready=1, busy=0, done=0, err=0.
REQ-031 Switch: req_sel=2 accepted at T0 -> clk_select=4'b0000 in T1..T4, 4'b0100 from T5, cur_sel=2 from T5, done=1 only in T9.
REQ-032 Busy drop: req_sel=1 held valid during T2..T6 of the above switch -> req_ready=0, request ignored, final clk_select=4'b0100.
REQ-033 Same index: req_sel=cur_sel=2 -> done in the next cycle, clk_select stays 4'b0100, busy never rises.
REQ-034 Out of range (NUM_CLOCKS=3): req_sel=3 -> err for 1 cycle, clk_select stays 3'b001.
REQ-035 Abort: rst at T2 of a 0->3 switch -> the following cycle shows clk_select=4'b0001 and IDLE, with no done pulse; a one-hot/zero assertion on clk_select holds across 10k random requests.
